// File: rtl/f_t_encode_stage.sv
// Registered lowest-set-bit encoder with valid/ready handshake and 2-entry skid buffer.
// Define F_T_ONEHOT_CHECK_EN to flag multi-hot inputs and count them in err_cnt.
module f_t_encode_stage #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_e,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_c,
    output logic         out_none,
    output logic         out_multi,
    output logic [7:0]   err_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [W-1:0] c;
        logic         none;
        logic         multi;
    } res_t;

    res_t             enc;
    res_t             m_q, m_d;
    res_t             s_q, s_d;
    logic             mv_q, mv_d;
    logic             sv_q, sv_d;
    logic             rdy_q;
    logic [CNT_W-1:0] err_q, err_d;
    logic [N-1:0]     e_g;
    logic             found;
    logic             bad;
    logic             acc;
    logic             drn;

    assign acc = in_valid & rdy_q;
    assign drn = mv_q & out_ready;

    // Gate the input with acc so an unaccepted (possibly X) vector never reaches state.
    always_comb begin
        e_g   = acc ? in_e : '0;
        enc   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (e_g[i] && !found) begin
                enc.c = W'(i);
                found = 1'b1;
            end
        end
        enc.none = ~|e_g;
`ifdef F_T_ONEHOT_CHECK_EN
        enc.multi = |(e_g & (e_g - N'(1)));
        bad       = enc.none | enc.multi;
`else
        enc.multi = 1'b0;
        bad       = enc.none;
`endif
    end

    // Main/skid occupancy transitions; S always drains into M before new data.
    always_comb begin
        m_d   = m_q;
        s_d   = s_q;
        mv_d  = mv_q;
        sv_d  = sv_q;
        err_d = err_q;
        if (!mv_q) begin
            if (acc) begin
                m_d  = enc;
                mv_d = 1'b1;
            end
        end else if (drn && !sv_q) begin
            if (acc) begin
                m_d = enc;
            end else begin
                mv_d = 1'b0;
            end
        end else if (drn && sv_q) begin
            m_d  = s_q;
            sv_d = 1'b0;
        end else if (!sv_q) begin
            if (acc) begin
                s_d  = enc;
                sv_d = 1'b1;
            end
        end
        if (acc && bad && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            s_q   <= '0;
            mv_q  <= 1'b0;
            sv_q  <= 1'b0;
            rdy_q <= 1'b1;
            err_q <= '0;
        end else begin
            m_q   <= m_d;
            s_q   <= s_d;
            mv_q  <= mv_d;
            sv_q  <= sv_d;
            rdy_q <= ~sv_d;
            err_q <= err_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = mv_q;
    assign out_c     = m_q.c;
    assign out_none  = m_q.none;
    assign out_multi = m_q.multi;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_f_t_encode_stage.sv
// Self-checking bench for f_t_encode_stage: directed table, backpressure, random scoreboard, saturation, reset.
module tb_f_t_encode_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_e;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_c;
    logic       out_none;
    logic       out_multi;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

`ifdef F_T_ONEHOT_CHECK_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    f_t_encode_stage #(.N(4), .W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_e(in_e),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_none(out_none), .out_multi(out_multi),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] e;
        logic [1:0] c;
        logic       none;
        logic       multi;
        logic [7:0] err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] low_idx(input logic [3:0] e);
        if (e[0]) return 2'd0;
        if (e[1]) return 2'd1;
        if (e[2]) return 2'd2;
        if (e[3]) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic is_bad(input logic [3:0] e);
        int pc;
        pc = $countones(e);
        return (pc == 0) || (MC && pc >= 2);
    endfunction

    logic [1:0] q[$];
    int         merr;
    logic       acc;
    logic       drn;
    logic       hold;
    logic [1:0] hold_c;

    initial begin
        tbl[0] = '{4'b0001, 2'd0, 1'b0, 1'b0, 8'd0};
        tbl[1] = '{4'b0010, 2'd1, 1'b0, 1'b0, 8'd0};
        tbl[2] = '{4'b0100, 2'd2, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{4'b1000, 2'd3, 1'b0, 1'b0, 8'd0};
        tbl[4] = '{4'b1010, 2'd1, 1'b0, MC,   MC ? 8'd1 : 8'd0};
        tbl[5] = '{4'b0000, 2'd0, 1'b1, 1'b0, MC ? 8'd2 : 8'd1};
        tbl[6] = '{4'b0110, 2'd1, 1'b0, MC,   MC ? 8'd3 : 8'd1};
        tbl[7] = '{4'b1111, 2'd0, 1'b0, MC,   MC ? 8'd4 : 8'd1};

        rst = 1'b1; in_valid = 1'b0; in_e = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_out_c", 32'(out_c), 32'd0);

        // Back-to-back stream, result visible one cycle after each accept.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_e = tbl[k].e;
            step();
            chk($sformatf("tbl%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_c", k), 32'(out_c), 32'(tbl[k].c));
            chk($sformatf("tbl%0d_none", k), 32'(out_none), 32'(tbl[k].none));
            chk($sformatf("tbl%0d_multi", k), 32'(out_multi), 32'(tbl[k].multi));
            chk($sformatf("tbl%0d_err", k), 32'(err_cnt), 32'(tbl[k].err));
            chk($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: A into M, B into S, C refused.
        out_ready = 1'b0;
        in_valid = 1'b1; in_e = 4'b0100;
        step();
        chk("bp_a_c", 32'(out_c), 32'd2);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        in_e = 4'b1000;
        step();
        chk("bp_b_ready", 32'(in_ready), 32'd0);
        chk("bp_b_c", 32'(out_c), 32'd2);
        in_e = 4'b0001;
        step();
        chk("bp_hold_c", 32'(out_c), 32'd2);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; in_e = 4'bxxxx; out_ready = 1'b1;
        step();
        chk("bp_b_out_c", 32'(out_c), 32'd3);
        chk("bp_b_out_valid", 32'(out_valid), 32'd1);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Random handshake against a queue model.
        merr = MC ? 4 : 1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_e      = 4'($urandom_range(0, 15));
            #1;
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            acc    = in_valid & in_ready;
            drn    = out_valid & out_ready;
            hold   = out_valid & ~out_ready;
            hold_c = out_c;
            if (drn) begin
                if (q.size() == 0) begin
                    chk("rnd_underflow", 32'd1, 32'd0);
                end else begin
                    chk("rnd_order", 32'(out_c), 32'(q.pop_front()));
                end
            end
            if (acc) begin
                q.push_back(low_idx(in_e));
                if (is_bad(in_e) && merr < 255) merr++;
            end
            step();
            if (hold) begin
                chk("rnd_stable_c", 32'(out_c), 32'(hold_c));
                chk("rnd_stable_v", 32'(out_valid), 32'd1);
            end
        end
        chk("rnd_err_cnt", 32'(err_cnt), 32'(merr));

        // Flush, then saturate the error counter.
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        in_valid = 1'b1; in_e = 4'b0000;
        for (int k = 0; k < 300; k++) step();
        chk("sat_err", 32'(err_cnt), 32'hFF);
        chk("sat_none", 32'(out_none), 32'd1);
        for (int k = 0; k < 5; k++) step();
        chk("sat_hold", 32'(err_cnt), 32'hFF);
        in_valid = 1'b0;
        step(); step();

        // Reset with M and S both full.
        out_ready = 1'b0; in_valid = 1'b1; in_e = 4'b0001;
        step();
        in_e = 4'b0100;
        step();
        chk("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_err_cnt", 32'(err_cnt), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_e = 4'b0010;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_c", 32'(out_c), 32'd1);
        in_valid = 1'b0;
        step();
        chk("post_rst_drain", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f_t_encode_stage.md
Name: f_t_encode_stage

Overview:
- Registered 4-to-2 priority encoder stage; inverse of the pipeline's 2-to-4 decode unit.
- Takes a one-hot select vector, produced for example by forwarding or hazard select logic, and returns a binary code.
- Valid/ready handshake on both sides.
- 2-entry skid buffer so in_ready never depends combinationally on out_ready.

Parameters:
- N, 4, number of select inputs; power of two, 2..16.
- W, 2, output code width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  upstream presents in_e
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready
- in_e  input  N  one-hot select vector; bit i means code i
- out_valid  output  1  out_* fields hold a valid result
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready
- out_c  output  W  encoded index
- out_none  output  1  accepted in_e was all-zero
- out_multi  output  1  accepted in_e had more than one bit set (feature-dependent)
- err_cnt  output  8  saturating count of accepted malformed vectors (feature-dependent)

Behaviour:
- Encoding rule: out_c = index of the lowest set bit of in_e. Example: in_e=4'b0110 -> out_c=1.
- All-zero in_e: out_c=0, out_none=1.
- Encoding is computed combinationally on accept and captured in a register. Nothing passes through combinationally to out_*.
- Storage: main register M (drives out_*) and skid register S, each with its own valid bit, mv and sv.
- in_ready = ~sv. It comes directly from a flop.
- out_valid = mv.
- Latency: a vector accepted in cycle t appears on out_* in cycle t+1 when M is free or is draining in cycle t.
- Per-cycle transitions, where acc = in_valid & in_ready and drn = mv & out_ready:
  - !mv: acc loads M.
  - mv & drn & !sv: acc loads M; otherwise mv clears.
  - mv & drn & sv: S moves to M, sv clears; in_ready=0 this cycle, so there is no acc.
  - mv & !drn & !sv: acc loads S, sv sets.
  - mv & !drn & sv: hold; in_ready=0.
- Accept and drain in the same cycle with M full and S empty: M reloads. Throughput is 1 per cycle with no bubble.
- Order is preserved: a transfer never overtakes S.
- While out_valid=1 and out_ready=0, out_* are held stable.
- Reset, including mid-transfer: mv=0, sv=0, out_c=0, out_none=0, out_multi=0, err_cnt=0, and in_ready=1 in the cycle after reset deasserts. Contents of M and S are discarded.
- in_e is sampled only on acc. X on in_e while not accepted must not propagate.
- err_cnt increments by 1 on each accepted vector that is all-zero or multi-hot. Saturates at 8'hFF with no wrap. Reset is the only clear.

Optional Feature:
- Macro: F_T_ONEHOT_CHECK_EN.
- Defined:
  - out_multi = 1 when popcount(in_e) >= 2 on the accepted vector.
  - err_cnt counts both zero and multi-hot vectors.
- Undefined:
  - out_multi tied 0.
  - err_cnt counts all-zero vectors only.
  - Popcount logic is removed.
  - Encoding rule is unchanged (lowest set bit).

Test Plan:
- Reset then stream 4'b0001, 4'b0010, 4'b0100, 4'b1000 with out_ready=1 -> out_c = 0,1,2,3 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1; err_cnt=0.
- in_e=4'b1010, then 4'b0000 -> out_c=1, out_multi=1 (macro on) / 0 (macro off); next result out_c=0, out_none=1; err_cnt=2 (macro on) / 1 (macro off).
- Backpressure: out_ready=0 while sending A=4'b0100, B=4'b1000 -> in_ready falls to 0 the cycle after B is accepted; out_c holds 2; then out_ready=1 -> out_c=2, then 3; in_ready returns to 1; no loss or duplication.
- Randomised in_valid/out_ready over 10k cycles with a scoreboard -> in-order delivery of all accepted vectors; out_* stable whenever out_valid & !out_ready.
- 300 consecutive all-zero accepts -> err_cnt reaches 8'hFF and stays there.
- Assert rst with M and S both full -> next cycle out_valid=0, in_ready=1, err_cnt=0; the first post-reset vector 4'b0010 yields out_c=1.
